spi_reg_slave: RTL

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

---
 rtl/spi_reg_slave.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave exposing an 8x8 register file, oversampled on the system clock.
// Frame: command byte {rw, 4'bx, addr[2:0]} followed by one data byte, both MSB first.
module spi_reg_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  RST_VAL     = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scki,
  input  logic       mosii,
  input  logic       ssn,
  output logic       misoo,
  output logic       misoo_oe,
  input  logic [2:0] host_addr,
  input  logic       host_we,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       wr_stb,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

  logic [SYNC_STAGES-1:0] scki_sync, mosi_sync, ssn_sync;
  logic [SYNC_STAGES:0]   arm_sync;
  logic                   scki_prev, ssn_prev;
  logic                   scki_s, mosi_s, ssn_s, armed;
  logic                   sck_rise, sck_fall, ssn_fall, ssn_rise;

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [7:0]  rx, rx_nxt;
  logic [7:0]  tx, tx_nxt;
  logic        rw, rw_nxt;
  logic [2:0]  addr, addr_nxt;
  logic        spi_we, ferr_nxt;
  logic [7:0]  spi_wdata;
  logic [7:0]  regs [8];

  // Input synchronizers and edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scki_sync <= '0;
      mosi_sync <= '0;
      ssn_sync  <= '1;
      arm_sync  <= '0;
      scki_prev <= 1'b0;
      ssn_prev  <= 1'b1;
    end else begin
      scki_sync <= {scki_sync[SYNC_STAGES-2:0], scki};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosii};
      ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], ssn};
      arm_sync  <= {arm_sync[SYNC_STAGES-1:0], 1'b1};
      scki_prev <= scki_s;
      ssn_prev  <= ssn_s;
    end
  end

  assign scki_s = scki_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ssn_s  = ssn_sync[SYNC_STAGES-1];
  // The ssn chain resets high; if the pin is already low at release, the chain
  // would show a false falling edge. Frame starts are ignored until it has flushed.
  assign armed  = arm_sync[SYNC_STAGES];

  assign sck_rise = scki_s & ~scki_prev;
  assign sck_fall = ~scki_s & scki_prev;
  assign ssn_fall = armed & ssn_prev & ~ssn_s;
  assign ssn_rise = ~ssn_prev & ssn_s;

  assign spi_wdata = {rx[6:0], mosi_s};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rx_nxt    = rx;
    tx_nxt    = tx;
    rw_nxt    = rw;
    addr_nxt  = addr;
    spi_we    = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (ssn_fall) begin
          state_nxt = CMD;
          cnt_nxt   = '0;
          rx_nxt    = '0;
          tx_nxt    = '0;
        end
      end
      CMD: begin
        if (ssn_rise) begin
          state_nxt = IDLE;
          ferr_nxt  = (cnt != 5'd0);
        end else if (sck_rise) begin
          rx_nxt  = spi_wdata;
          cnt_nxt = cnt + 5'd1;
          if (cnt == 5'd7) begin
            rw_nxt    = rx[6];
            addr_nxt  = {rx[1:0], mosi_s};
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (ssn_rise) begin
          state_nxt = IDLE;
          ferr_nxt  = 1'b1;
        end else if (sck_rise) begin
          rx_nxt  = spi_wdata;
          cnt_nxt = cnt + 5'd1;
          if (cnt == 5'd15) begin
            state_nxt = HOLD;
            spi_we    = ~rw;
          end
        end else if (sck_fall && rw) begin
          // First fall after the command byte loads; later falls shift out
          if (cnt == 5'd8) tx_nxt = regs[addr];
          else             tx_nxt = {tx[6:0], 1'b0};
        end
      end
      HOLD: begin
        if (ssn_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rx    <= '0;
      tx    <= '0;
      rw    <= 1'b0;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rx    <= rx_nxt;
      tx    <= tx_nxt;
      rw    <= rw_nxt;
      addr  <= addr_nxt;
    end
  end

  // Register file: an SPI write takes precedence over a host write to the same address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (spi_we && addr == 3'(i))
          regs[i] <= spi_wdata;
        else if (host_we && host_addr == 3'(i))
          regs[i] <= host_wdata;
      end
    end
  end

  // Write notification and abort strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_stb    <= spi_we;
      frame_err <= ferr_nxt;
      if (spi_we) begin
        wr_addr <= addr;
        wr_data <= spi_wdata;
      end
    end
  end

  assign host_rdata = regs[host_addr];
  assign misoo      = (state == DATA) & tx[7];
  assign misoo_oe   = ~ssn_s;

endmodule
